vga_pixel_stream: RTL and testbench

- Display-side stage directly downstream of the video timing controller (vtc).
- Consumes vtc timing (vsync, hsync, active, counterX/counterY) and pops RGB565 pixels from a first-word-fall-through (FWFT) frame FIFO fed by the capture/processing path.
- Emits registered RGB888 plus timing delayed to match, ready for the DVI/VGA encoder.
- Locks to the frame using a start-of-frame (SOF) tag bit carried in the FIFO word.
- Recovers from underflow or misalignment by resynchronising at the next frame.

---
 rtl/video_pkg.sv | 16 +
 rtl/rgb565_to_888.sv | 12 +
 rtl/vga_pixel_stream.sv | 112 +++++++++++
 tb/tb_vga_pixel_stream.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared display-path definitions: pixel-stream FSM states, FIFO word layout
// and default colours.
package video_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } pix_state_t;

  localparam int FIFO_W  = 17;
  localparam int SOF_BIT = 16;

  localparam logic [23:0] BLANK_RGB     = 24'h000000;
  localparam logic [23:0] UNDERFLOW_RGB = 24'hFF00FF;

endpackage

// File: rtl/rgb565_to_888.sv
// RGB565 to RGB888 expander; each channel's MSBs are replicated into the new
// LSBs so full scale maps to full scale.
module rgb565_to_888 (
  input  logic [15:0] rgb565,
  output logic [23:0] rgb888
);

  assign rgb888 = {rgb565[15:11], rgb565[15:13],
                   rgb565[10:5],  rgb565[10:9],
                   rgb565[4:0],   rgb565[4:2]};

endmodule

// File: rtl/vga_pixel_stream.sv
// Pops RGB565 pixels from an FWFT frame FIFO in step with vtc timing, locking
// to the frame via the SOF tag and resynchronising after underflow/misalignment.
module vga_pixel_stream
  import video_pkg::*;
#(
  parameter int          CNT_W           = 10,
  parameter logic [23:0] BLANK_COLOR     = BLANK_RGB,
  parameter logic [23:0] UNDERFLOW_COLOR = UNDERFLOW_RGB
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_vsync,
  input  logic              i_hsync,
  input  logic              i_active,
  input  logic [CNT_W-1:0]  i_counterX,
  input  logic [CNT_W-1:0]  i_counterY,
  input  logic [FIFO_W-1:0] i_fifo_data,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rden,
  input  logic              i_err_clr,
  output logic              o_vsync,
  output logic              o_hsync,
  output logic              o_active,
  output logic [23:0]       o_rgb,
  output logic              o_locked,
  output logic              o_underflow,
  output logic              o_misalign
);

  pix_state_t  state, state_nxt;
  logic [23:0] head_rgb;
  logic [23:0] rgb_nxt;
  logic        rden_c;
  logic        set_uf, set_ma;
  logic        fs, head_tag, head_sof;

  rgb565_to_888 u_expand (
    .rgb565 (i_fifo_data[15:0]),
    .rgb888 (head_rgb)
  );

  assign fs       = i_active && (i_counterX == '0) && (i_counterY == '0);
  assign head_tag = i_fifo_data[SOF_BIT];
  assign head_sof = head_tag && !i_fifo_empty;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    rgb_nxt   = BLANK_COLOR;
    rden_c    = 1'b0;
    set_uf    = 1'b0;
    set_ma    = 1'b0;
    unique case (state)
      SYNC: begin
        if (!i_fifo_empty && !head_tag) begin
          rden_c = 1'b1;
        end else if (head_sof && fs) begin
          rden_c    = 1'b1;
          rgb_nxt   = head_rgb;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!i_active) begin
          rgb_nxt = BLANK_COLOR;
        end else if (i_fifo_empty) begin
          // Empty is tested before the SOF/fs match, so an empty FIFO at fs
          // is reported as underflow rather than misalignment.
          rgb_nxt   = UNDERFLOW_COLOR;
          set_uf    = 1'b1;
          state_nxt = SYNC;
        end else if (head_tag == fs) begin
          rden_c  = 1'b1;
          rgb_nxt = head_rgb;
        end else begin
          set_ma    = 1'b1;
          state_nxt = SYNC;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Reset forces SYNC, but SYNC drains stale words; mask the pop during reset.
  assign o_fifo_rden = rden_c && i_rstn;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= SYNC;
      o_vsync     <= 1'b0;
      o_hsync     <= 1'b0;
      o_active    <= 1'b0;
      o_rgb       <= BLANK_COLOR;
      o_locked    <= 1'b0;
      o_underflow <= 1'b0;
      o_misalign  <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_vsync     <= i_vsync;
      o_hsync     <= i_hsync;
      o_active    <= i_active;
      o_rgb       <= rgb_nxt;
      o_locked    <= (state_nxt == RUN);
      o_underflow <= set_uf || (o_underflow && !i_err_clr);
      o_misalign  <= set_ma || (o_misalign && !i_err_clr);
    end
  end

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Directed bench for vga_pixel_stream on a reduced 8x4 active raster
// (12x6 total) with a queue-based FWFT FIFO model.
module tb_vga_pixel_stream;

  localparam int CNT_W = 10;
  localparam int H_ACT = 8;
  localparam int V_ACT = 4;
  localparam int H_TOT = 12;
  localparam int V_TOT = 6;
  localparam int FRAME = H_ACT * V_ACT;
  localparam logic [23:0] BLANK = 24'h000000;
  localparam logic [23:0] UFCOL = 24'hFF00FF;

  logic             i_clk = 1'b0;
  logic             i_rstn;
  logic             i_vsync, i_hsync, i_active;
  logic [CNT_W-1:0] i_counterX, i_counterY;
  logic [16:0]      i_fifo_data;
  logic             i_fifo_empty;
  logic             o_fifo_rden;
  logic             i_err_clr;
  logic             o_vsync, o_hsync, o_active;
  logic [23:0]      o_rgb;
  logic             o_locked, o_underflow, o_misalign;

  vga_pixel_stream #(.CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_vsync      (i_vsync),
    .i_hsync      (i_hsync),
    .i_active     (i_active),
    .i_counterX   (i_counterX),
    .i_counterY   (i_counterY),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rden  (o_fifo_rden),
    .i_err_clr    (i_err_clr),
    .o_vsync      (o_vsync),
    .o_hsync      (o_hsync),
    .o_active     (o_active),
    .o_rgb        (o_rgb),
    .o_locked     (o_locked),
    .o_underflow  (o_underflow),
    .o_misalign   (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  logic [16:0] fifo_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int hc, vc, pop_count;
  int prev_x, prev_y;
  logic prev_act, prev_hs, prev_vs;

  function automatic logic [23:0] expand(logic [15:0] p);
    logic [4:0] r, b;
    logic [5:0] g;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

  function automatic logic [15:0] px(int f, int idx);
    if (f == 1 && idx == 0) return 16'hFFFF;
    if (f == 1 && idx == 1) return 16'hF800;
    return 16'(f * 4099 + idx * 2117);
  endfunction

  task automatic push_frame(int f, int n);
    for (int i = 0; i < n; i++) fifo_q.push_back({(i == 0), px(f, i)});
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int cur_idx();
    return vc * H_ACT + hc;
  endfunction

  function automatic logic cur_act();
    return (hc < H_ACT) && (vc < V_ACT);
  endfunction

  task automatic drive();
    i_active     = cur_act();
    i_counterX   = CNT_W'(hc);
    i_counterY   = CNT_W'(vc);
    i_hsync      = (hc >= 9) && (hc < 11);
    i_vsync      = (vc == V_TOT - 1);
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = i_fifo_empty ? 17'h0 : fifo_q[0];
  endtask

  // One pixel clock: drive at posedge+1, sample rden mid-cycle, pop on the
  // edge, then check the one-cycle timing delay at posedge+1.
  task automatic tick();
    logic rd, en;
    drive();
    #4;
    rd       = o_fifo_rden;
    en       = i_rstn;
    prev_act = i_active;
    prev_hs  = i_hsync;
    prev_vs  = i_vsync;
    prev_x   = hc;
    prev_y   = vc;
    @(posedge i_clk);
    if (rd && fifo_q.size() > 0) begin
      fifo_q.delete(0);
      pop_count++;
    end
    hc++;
    if (hc == H_TOT) begin
      hc = 0;
      vc = (vc + 1) % V_TOT;
    end
    #1;
    if (en) begin
      chk("active_dly", 32'(o_active), 32'(prev_act));
      chk("hsync_dly", 32'(o_hsync), 32'(prev_hs));
      chk("vsync_dly", 32'(o_vsync), 32'(prev_vs));
    end
  endtask

  initial begin
    int idx;
    logic [23:0] exp;
    logic lk, uf_seen;

    i_rstn = 1'b0;
    i_err_clr = 1'b0;
    hc = 0;
    vc = V_ACT;
    pop_count = 0;
    drive();
    @(posedge i_clk);
    #1;

    // Reset held with stale words queued: nothing may pop.
    fifo_q.push_back({1'b0, 16'hDEAD});
    fifo_q.push_back({1'b0, 16'hBEEF});
    tick();
    tick();
    chk("rst_rden", 32'(o_fifo_rden), 32'd0);
    chk("rst_rgb", 32'(o_rgb), 32'(BLANK));
    chk("rst_locked", 32'(o_locked), 32'd0);
    chk("rst_uf", 32'(o_underflow), 32'd0);
    chk("rst_ma", 32'(o_misalign), 32'd0);
    chk("rst_active", 32'(o_active), 32'd0);
    chk("rst_pops", 32'(pop_count), 32'd0);

    // Frame 1: SOF at head, hold through blanking, lock at fs.
    fifo_q.delete();
    i_rstn = 1'b1;
    push_frame(1, FRAME);
    while (!(hc == 0 && vc == 0)) begin
      tick();
      chk("pre_rgb", 32'(o_rgb), 32'(BLANK));
      chk("pre_locked", 32'(o_locked), 32'd0);
    end
    chk("pre_pops", 32'(pop_count), 32'd0);
    pop_count = 0;
    repeat (H_TOT * V_TOT) begin
      tick();
      idx = prev_y * H_ACT + prev_x;
      if (!prev_act) exp = BLANK;
      else if (idx == 0) exp = 24'hFFFFFF;
      else if (idx == 1) exp = 24'hFF0000;
      else exp = expand(px(1, idx));
      chk("f1_rgb", 32'(o_rgb), 32'(exp));
      chk("f1_locked", 32'(o_locked), 32'd1);
    end
    chk("f1_pops", 32'(pop_count), 32'(FRAME));
    chk("f1_uf", 32'(o_underflow), 32'd0);
    chk("f1_ma", 32'(o_misalign), 32'd0);

    // Frame 2: FIFO runs dry at X=5,Y=2; then junk + frame 3 arrive.
    pop_count = 0;
    uf_seen = 1'b0;
    push_frame(2, 21);
    repeat (H_TOT * V_TOT) begin
      tick();
      idx = prev_y * H_ACT + prev_x;
      if (prev_act && idx == 21) begin
        chk("uf_rgb", 32'(o_rgb), 32'(UFCOL));
        chk("uf_flag", 32'(o_underflow), 32'd1);
        chk("uf_locked", 32'(o_locked), 32'd0);
        uf_seen = 1'b1;
        fifo_q.push_back({1'b0, 16'h1111});
        fifo_q.push_back({1'b0, 16'h2222});
        fifo_q.push_back({1'b0, 16'h3333});
        push_frame(3, FRAME);
      end else begin
        exp = (prev_act && !uf_seen) ? expand(px(2, idx)) : BLANK;
        lk  = !uf_seen;
        chk("f2_rgb", 32'(o_rgb), 32'(exp));
        chk("f2_locked", 32'(o_locked), 32'(lk));
      end
    end
    chk("f2_pops", 32'(pop_count), 32'd24);
    chk("f2_head_sof", 32'(fifo_q.size()), 32'(FRAME));

    // Frame 3: relock; lone err_clr pulse drops the underflow flag.
    pop_count = 0;
    for (int k = 0; k < H_TOT * V_TOT; k++) begin
      i_err_clr = (k == 39);
      tick();
      i_err_clr = 1'b0;
      idx = prev_y * H_ACT + prev_x;
      exp = prev_act ? expand(px(3, idx)) : BLANK;
      chk("f3_rgb", 32'(o_rgb), 32'(exp));
      chk("f3_locked", 32'(o_locked), 32'd1);
      chk("f3_uf", 32'(o_underflow), 32'(k < 39));
    end
    chk("f3_pops", 32'(pop_count), 32'(FRAME));

    // Frame 4: two pixels dropped upstream, SOF of frame 5 shows up at X=6,Y=3.
    pop_count = 0;
    push_frame(4, FRAME - 2);
    push_frame(5, FRAME);
    repeat (H_TOT * V_TOT) begin
      i_err_clr = cur_act() && (cur_idx() == FRAME - 2);
      tick();
      i_err_clr = 1'b0;
      idx = prev_y * H_ACT + prev_x;
      if (prev_act && idx >= FRAME - 2) begin
        chk("ma_rgb", 32'(o_rgb), 32'(BLANK));
        chk("ma_flag", 32'(o_misalign), 32'd1);
        chk("ma_locked", 32'(o_locked), 32'd0);
      end else if (prev_act) begin
        chk("f4_rgb", 32'(o_rgb), 32'(expand(px(4, idx))));
        chk("f4_locked", 32'(o_locked), 32'd1);
      end
    end
    chk("f4_pops", 32'(pop_count), 32'(FRAME - 2));
    chk("f4_ma_hold", 32'(o_misalign), 32'd1);

    // Frame 5: relock with correct data, clear misalign, then reset at X=3,Y=1.
    for (int k = 0; !(vc == 1 && hc == 3); k++) begin
      i_err_clr = (k == 5);
      tick();
      i_err_clr = 1'b0;
      idx = prev_y * H_ACT + prev_x;
      exp = prev_act ? expand(px(5, idx)) : BLANK;
      chk("f5_rgb", 32'(o_rgb), 32'(exp));
      chk("f5_locked", 32'(o_locked), 32'd1);
      chk("f5_ma", 32'(o_misalign), 32'(k < 5));
    end
    #2;
    i_rstn = 1'b0;
    #1;
    chk("mid_rst_rgb", 32'(o_rgb), 32'(BLANK));
    chk("mid_rst_active", 32'(o_active), 32'd0);
    chk("mid_rst_hsync", 32'(o_hsync), 32'd0);
    chk("mid_rst_locked", 32'(o_locked), 32'd0);
    chk("mid_rst_rden", 32'(o_fifo_rden), 32'd0);
    tick();
    i_rstn = 1'b1;
    push_frame(6, FRAME);
    while (!(hc == 0 && vc == 0)) begin
      tick();
      chk("post_rst_rgb", 32'(o_rgb), 32'(BLANK));
      chk("post_rst_locked", 32'(o_locked), 32'd0);
    end
    chk("post_rst_drain", 32'(fifo_q.size()), 32'(FRAME));

    // Frame 6: relock only at this fs.
    pop_count = 0;
    repeat (H_TOT * V_TOT) begin
      tick();
      idx = prev_y * H_ACT + prev_x;
      exp = prev_act ? expand(px(6, idx)) : BLANK;
      chk("f6_rgb", 32'(o_rgb), 32'(exp));
      chk("f6_locked", 32'(o_locked), 32'd1);
    end
    chk("f6_pops", 32'(pop_count), 32'(FRAME));
    chk("f6_uf", 32'(o_underflow), 32'd0);
    chk("f6_ma", 32'(o_misalign), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
